// File: rtl/fetch_pc_gen.sv
// IF1 fetch stage: owns the fetch PC, issues aligned 64-bit cache requests and packs in-order
// responses into one or two instruction packets, discarding responses that predate a redirect.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ds_flush,
  input  logic [31:0]  flush_pc,
  input  logic         fifo_allowin,
  output logic         inst_req,
  output logic [31:0]  inst_addr,
  input  logic         inst_addr_ok,
  input  logic         inst_data_ok,
  input  logic [63:0]  inst_rdata,
  output logic         valid_i_0,
  output logic         valid_i_1,
  output logic [101:0] icache_bus_0,
  output logic [101:0] icache_bus_1
);

  localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [4:0]  EXC_ADEL = 5'h04;
  localparam logic [CNT_W:0]   MAX_CNT  = MAX_OUTSTANDING[CNT_W:0];
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] cancel_q, cancel_d;
  logic [31:0]      tag_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             hold_full_q, hold_full_d;
  logic [31:0]      hold_pc_q, hold_pc_d;
  logic [63:0]      hold_data_q, hold_data_d;

  logic             accept;
  logic             resp_live;
  logic             adel;
  logic             emit_hold;
  logic             emit_adel;
  logic [CNT_W:0]   in_use;
  logic [31:0]      tag_head;

  function automatic logic [101:0] make_pkt(input logic [31:0] pc, input logic [31:0] inst);
    return {1'b0, 5'd0, pc + 32'd4, inst, pc};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_use    = {1'b0, outstanding_q} + {{CNT_W{1'b0}}, hold_full_q};
  assign accept    = inst_req && inst_addr_ok;
  assign resp_live = inst_data_ok && (cancel_q == '0);
  assign tag_head  = tag_q[rd_ptr_q];
  assign adel      = !reset && !ds_flush && (state_q == StRun) && (pc_q[1:0] != 2'b00) &&
                     (outstanding_q == '0) && !hold_full_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (ds_flush) begin
      state_d = StRun;
    end else if (emit_adel) begin
      state_d = StHalt;
    end
  end

  // Outputs
  always_comb begin
    inst_req     = 1'b0;
    inst_addr    = 32'h0;
    valid_i_0    = 1'b0;
    valid_i_1    = 1'b0;
    icache_bus_0 = '0;
    icache_bus_1 = '0;
    emit_hold    = 1'b0;
    emit_adel    = 1'b0;
    if (!reset) begin
      inst_addr = {pc_q[31:3], 3'b000};
      inst_req  = (state_q == StRun) && !ds_flush && (in_use < MAX_CNT) &&
                  (pc_q[1:0] == 2'b00);
      if (!ds_flush) begin
        if (hold_full_q && fifo_allowin) begin
          emit_hold    = 1'b1;
          valid_i_0    = 1'b1;
          valid_i_1    = !hold_pc_q[2];
          icache_bus_0 = make_pkt(hold_pc_q, hold_pc_q[2] ? hold_data_q[63:32] : hold_data_q[31:0]);
          if (!hold_pc_q[2]) begin
            icache_bus_1 = make_pkt(hold_pc_q + 32'd4, hold_data_q[63:32]);
          end
        end else if (resp_live && fifo_allowin) begin
          valid_i_0    = 1'b1;
          valid_i_1    = !tag_head[2];
          icache_bus_0 = make_pkt(tag_head, tag_head[2] ? inst_rdata[63:32] : inst_rdata[31:0]);
          if (!tag_head[2]) begin
            icache_bus_1 = make_pkt(tag_head + 32'd4, inst_rdata[63:32]);
          end
        end else if (adel && fifo_allowin) begin
          emit_adel    = 1'b1;
          valid_i_0    = 1'b1;
          icache_bus_0 = {1'b1, EXC_ADEL, pc_q, 32'h0, pc_q};
        end
      end
    end
  end

  // Datapath next state
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    cancel_d      = cancel_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    hold_full_d   = hold_full_q;
    hold_pc_d     = hold_pc_q;
    hold_data_d   = hold_data_q;

    if (accept && !inst_data_ok) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!accept && inst_data_ok) begin
      outstanding_d = outstanding_q - 1'b1;
    end

    if (ds_flush) begin
      pc_d        = flush_pc;
      // Every request still in flight is stale; cancel_q entries are already among them.
      cancel_d    = outstanding_q - CNT_W'(inst_data_ok);
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      hold_full_d = 1'b0;
    end else begin
      if (accept) begin
        pc_d     = pc_q[2] ? pc_q + 32'd4 : pc_q + 32'd8;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (inst_data_ok && (cancel_q != '0)) begin
        cancel_d = cancel_q - 1'b1;
      end
      if (resp_live) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (resp_live && (!fifo_allowin || hold_full_q)) begin
        hold_full_d = 1'b1;
        hold_pc_d   = tag_head;
        hold_data_d = inst_rdata;
      end else if (emit_hold) begin
        hold_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      cancel_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      hold_full_q   <= 1'b0;
      hold_pc_q     <= 32'h0;
      hold_data_q   <= 64'h0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      cancel_q      <= cancel_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      hold_full_q   <= hold_full_d;
      hold_pc_q     <= hold_pc_d;
      hold_data_q   <= hold_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q[wr_ptr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: acts as the instruction cache and checks every cycle against a
// transaction-level model (queue of in-flight requests, each tagged stale or live).
module tb_fetch_pc_gen;

  logic         clk;
  logic         reset;
  logic         ds_flush;
  logic [31:0]  flush_pc;
  logic         fifo_allowin;
  logic         inst_req;
  logic [31:0]  inst_addr;
  logic         inst_addr_ok;
  logic         inst_data_ok;
  logic [63:0]  inst_rdata;
  logic         valid_i_0;
  logic         valid_i_1;
  logic [101:0] icache_bus_0;
  logic [101:0] icache_bus_1;

  int vectors;
  int miscompares;

  fetch_pc_gen dut (
    .clk          (clk),
    .reset        (reset),
    .ds_flush     (ds_flush),
    .flush_pc     (flush_pc),
    .fifo_allowin (fifo_allowin),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .valid_i_0    (valid_i_0),
    .valid_i_1    (valid_i_1),
    .icache_bus_0 (icache_bus_0),
    .icache_bus_1 (icache_bus_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } req_t;

  req_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_hold_full;
  logic [31:0] m_hold_pc;
  logic [63:0] m_hold_data;

  function automatic logic [101:0] pk(input logic ex, input logic [4:0] code,
                                      input logic [31:0] pd, input logic [31:0] ins,
                                      input logic [31:0] p);
    return {ex, code, pd, ins, p};
  endfunction

  task automatic chk(input string name, input logic [101:0] act, input logic [101:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc        = 32'hbfc00000;
    m_halted    = 0;
    m_hold_full = 0;
    m_hold_pc   = 0;
    m_hold_data = 0;
  endtask

  // Expected packets for a fetch whose tag pc is t: words from t up to the end of the 8-byte line.
  task automatic expect_pkts(input logic [31:0] t, input logic [63:0] rd, output bit v1,
                             output logic [101:0] b0, output logic [101:0] b1);
    logic [31:0] w[2];
    int          first;
    w[0]  = rd[31:0];
    w[1]  = rd[63:32];
    first = int'(t[2]);
    b0    = pk(1'b0, 5'd0, t + 4, w[first], t);
    v1    = (first == 0);
    b1    = v1 ? pk(1'b0, 5'd0, t + 8, w[1], t + 4) : '0;
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b1;
    ds_flush     = 1'b0;
    flush_pc     = 32'h0;
    fifo_allowin = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 64'h0;
    repeat (n) begin
      #3;
      chk("rst_req", inst_req, 0);
      chk("rst_v0", valid_i_0, 0);
      chk("rst_v1", valid_i_1, 0);
      tick();
    end
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance the model.
  task automatic step(input bit fl, input logic [31:0] fpc, input bit al, input bit aok,
                      input bit dok, input logic [63:0] rd);
    bit           exp_req, live, ev0, ev1, adel, emit_hold, new_cap;
    logic [101:0] eb0, eb1;
    req_t         head;
    ds_flush     = fl;
    flush_pc     = fpc;
    fifo_allowin = al;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rd;
    #3;
    exp_req = !m_halted && !fl && (m_q.size() + int'(m_hold_full)) < 2 && m_pc[1:0] == 2'b00;
    live    = dok && m_q.size() > 0 && !m_q[0].stale;
    ev0 = 0; ev1 = 0; eb0 = '0; eb1 = '0; adel = 0;
    if (!fl) begin
      if (m_hold_full && al) begin
        ev0 = 1;
        expect_pkts(m_hold_pc, m_hold_data, ev1, eb0, eb1);
      end else if (live && al) begin
        ev0 = 1;
        expect_pkts(m_q[0].pc, rd, ev1, eb0, eb1);
      end else if (!m_halted && m_pc[1:0] != 2'b00 && m_q.size() == 0 && !m_hold_full && al) begin
        ev0  = 1;
        adel = 1;
        eb0  = pk(1'b1, 5'h04, m_pc, 32'h0, m_pc);
      end
    end
    chk("inst_req", inst_req, exp_req);
    if (exp_req) chk("inst_addr", inst_addr, m_pc & 32'hffff_fff8);
    chk("valid_i_0", valid_i_0, ev0);
    chk("valid_i_1", valid_i_1, ev1);
    chk("icache_bus_0", icache_bus_0, eb0);
    chk("icache_bus_1", icache_bus_1, eb1);

    emit_hold = !fl && m_hold_full && al;
    new_cap   = !fl && live && (!al || m_hold_full);
    if (dok && m_q.size() > 0) begin
      head = m_q.pop_front();
      if (new_cap) begin
        m_hold_pc   = head.pc;
        m_hold_data = rd;
      end
    end
    if (fl) m_hold_full = 0;
    else if (new_cap) m_hold_full = 1;
    else if (emit_hold) m_hold_full = 0;
    if (fl) begin
      foreach (m_q[i]) m_q[i].stale = 1;
      m_pc     = fpc;
      m_halted = 0;
    end else begin
      if (exp_req && aok) begin
        m_q.push_back('{pc: m_pc, stale: 0});
        m_pc = m_pc[2] ? m_pc + 4 : m_pc + 8;
      end
      if (adel) m_halted = 1;
    end
  endtask

  initial begin
    logic [31:0] tmp;
    bit          fl, al, aok, dok;
    logic [31:0] fpc;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);

    // 1: first fetch from reset vector, cache answers next cycle
    step(0, 0, 1, 1, 0, 0);
    chk("t1_req", inst_req, 1);
    chk("t1_addr", inst_addr, 32'hbfc00000);
    tick();
    step(0, 0, 1, 0, 1, 64'h22222222_11111111);
    chk("t1_v0", valid_i_0, 1);
    chk("t1_v1", valid_i_1, 1);
    chk("t1_bus0", icache_bus_0, pk(0, 0, 32'hbfc00004, 32'h11111111, 32'hbfc00000));
    chk("t1_bus1", icache_bus_1, pk(0, 0, 32'hbfc00008, 32'h22222222, 32'hbfc00004));
    chk("t1_next", inst_addr, 32'hbfc00008);
    tick();

    // 2: redirect to upper word of a line
    step(1, 32'h80000104, 1, 0, 0, 0);
    chk("t2_flush_v0", valid_i_0, 0);
    tick();
    step(0, 0, 1, 1, 0, 0);
    chk("t2_addr", inst_addr, 32'h80000100);
    tick();
    step(0, 0, 1, 0, 1, 64'hAAAAAAAA_55555555);
    chk("t2_v1", valid_i_1, 0);
    chk("t2_bus0", icache_bus_0, pk(0, 0, 32'h80000108, 32'hAAAAAAAA, 32'h80000104));
    chk("t2_next", inst_addr, 32'h80000108);
    tick();

    // 3: two in flight, then a flush discards both responses
    step(0, 0, 1, 1, 0, 0);
    tick();
    step(0, 0, 1, 1, 0, 0);
    tick();
    step(1, 32'h80001000, 1, 0, 0, 0);
    tick();
    step(0, 0, 1, 0, 1, 64'h0123456789abcdef);
    chk("t3_drop1", valid_i_0, 0);
    tick();
    step(0, 0, 1, 1, 1, 64'hfedcba9876543210);
    chk("t3_drop2", valid_i_0, 0);
    chk("t3_addr", inst_addr, 32'h80001000);
    tick();
    step(0, 0, 1, 0, 1, 64'h44444444_33333333);
    chk("t3_bus0", icache_bus_0, pk(0, 0, 32'h80001004, 32'h33333333, 32'h80001000));
    tick();

    // 4: FIFO back-pressure holds one response
    step(0, 0, 1, 1, 0, 0);
    tick();
    step(0, 0, 1, 1, 0, 0);
    tick();
    step(0, 0, 0, 0, 1, 64'h66666666_77777777);
    chk("t4_held_v0", valid_i_0, 0);
    tick();
    step(0, 0, 0, 1, 0, 0);
    chk("t4_req_blocked", inst_req, 0);
    tick();
    step(0, 0, 1, 1, 0, 0);
    chk("t4_bus0", icache_bus_0, pk(0, 0, 32'h8000100c, 32'h77777777, 32'h80001008));
    chk("t4_bus1", icache_bus_1, pk(0, 0, 32'h80001010, 32'h66666666, 32'h8000100c));
    tick();
    step(0, 0, 1, 0, 1, 64'h5a5a5a5a_a5a5a5a5);
    tick();

    // 5: misaligned redirect raises AdEL then halts until the next flush
    step(1, 32'h80000002, 1, 0, 0, 0);
    tick();
    step(0, 0, 1, 1, 0, 0);
    chk("t5_bus0", icache_bus_0, pk(1, 5'h04, 32'h80000002, 32'h0, 32'h80000002));
    chk("t5_v1", valid_i_1, 0);
    chk("t5_req", inst_req, 0);
    tick();
    repeat (3) begin
      step(0, 0, 1, 1, 0, 0);
      chk("t5_halt_v0", valid_i_0, 0);
      tick();
    end
    step(1, 32'h80000000, 1, 0, 0, 0);
    tick();
    step(0, 0, 1, 1, 0, 0);
    chk("t5_resume", inst_addr, 32'h80000000);
    tick();
    step(0, 0, 1, 0, 1, 64'h1);
    tick();

    // 6: address wrap at the top of memory
    step(1, 32'hfffffff8, 1, 0, 0, 0);
    tick();
    step(0, 0, 1, 1, 0, 0);
    chk("t6_addr", inst_addr, 32'hfffffff8);
    tick();
    step(0, 0, 1, 0, 1, 64'h99999999_88888888);
    chk("t6_bus1", icache_bus_1, pk(0, 0, 32'h00000000, 32'h99999999, 32'hfffffffc));
    chk("t6_wrap", inst_addr, 32'h00000000);
    tick();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset(2);
      fl  = ($urandom_range(0, 99) < 4);
      tmp = $urandom();
      case ($urandom_range(0, 9))
        0:       fpc = 32'hfffffff8 | (tmp & 32'h4);
        1:       fpc = (tmp & 32'hffff_fffc) | 32'h1 | (tmp & 32'h2);
        default: fpc = tmp & 32'hffff_fffc;
      endcase
      al  = ($urandom_range(0, 99) < 75);
      aok = ($urandom_range(0, 99) < 70);
      dok = (m_q.size() > 0) && !(m_hold_full && !al) && ($urandom_range(0, 99) < 50);
      step(fl, fpc, al, aok, dok, {$urandom(), $urandom()});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
